// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/scoreboard bus bundle for regfile_mp (HI/LO signals under REGFILE_HILO_EN)
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
);
    // Read ports
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rvalid;

    // Write ports
    logic [NWR-1:0]        we;
    logic [NWR*ADDR_W-1:0] waddr;
    logic [NWR*DATA_W-1:0] wdata;

    // Scoreboard control and status
    logic                  issue_we;
    logic [ADDR_W-1:0]     issue_addr;
    logic                  flush;
    logic [ADDR_W:0]       pend_cnt;

`ifdef REGFILE_HILO_EN
    logic [1:0]            hilo_we;
    logic [63:0]           hilo_wdata;
    logic [31:0]           hi_rdata;
    logic [31:0]           lo_rdata;
    logic                  hilo_pend;
    logic                  hilo_issue;

    modport master (
        output raddr, we, waddr, wdata, issue_we, issue_addr, flush,
               hilo_we, hilo_wdata, hilo_issue,
        input  rdata, rvalid, pend_cnt, hi_rdata, lo_rdata, hilo_pend
    );

    modport slave (
        input  raddr, we, waddr, wdata, issue_we, issue_addr, flush,
               hilo_we, hilo_wdata, hilo_issue,
        output rdata, rvalid, pend_cnt, hi_rdata, lo_rdata, hilo_pend
    );
`else
    modport master (
        output raddr, we, waddr, wdata, issue_we, issue_addr, flush,
        input  rdata, rvalid, pend_cnt
    );

    modport slave (
        input  raddr, we, waddr, wdata, issue_we, issue_addr, flush,
        output rdata, rvalid, pend_cnt
    );
`endif
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port GPR file with write bypass and pending scoreboard (optional HI/LO via REGFILE_HILO_EN)
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [ADDR_W:0]   pend_cnt_q;
    logic [ADDR_W:0]   pend_cnt_d;

    logic [NRD*DATA_W-1:0] rdata_c;
    logic [NRD-1:0]        rvalid_c;

    // Register 0 is hardwired only when ZERO_REG is set
    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Next storage state: ports applied in ascending order so the highest index wins
    always_comb begin : write_comb
        logic [ADDR_W-1:0] wa;
        wa = '0;
        for (int r = 0; r < DEPTH; r++) begin
            mem_d[r] = mem_q[r];
        end
        for (int j = 0; j < NWR; j++) begin
            wa = bus.waddr[j*ADDR_W +: ADDR_W];
            if (bus.we[j] && !is_zero(wa)) begin
                mem_d[wa] = bus.wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    // Next pending vector (flush > issue > writeback > hold) and its population count
    always_comb begin : pend_comb
        logic wr_hit;
        wr_hit     = 1'b0;
        pend_d     = pend_q;
        pend_cnt_d = '0;
        for (int r = 0; r < DEPTH; r++) begin
            wr_hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (bus.we[j] && (bus.waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    wr_hit = 1'b1;
                end
            end
            if (bus.flush) begin
                pend_d[r] = 1'b0;
            end else if (bus.issue_we && (bus.issue_addr == ADDR_W'(r))) begin
                pend_d[r] = 1'b1;
            end else if (wr_hit) begin
                pend_d[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
        for (int r = 0; r < DEPTH; r++) begin
            pend_cnt_d = pend_cnt_d + {{ADDR_W{1'b0}}, pend_d[r]};
        end
    end

    // Combinational read with same-cycle bypass from the highest-index matching write port
    always_comb begin : read_comb
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data;
        logic              hit;
        ra       = '0;
        data     = '0;
        hit      = 1'b0;
        rdata_c  = '0;
        rvalid_c = '0;
        for (int i = 0; i < NRD; i++) begin
            ra   = bus.raddr[i*ADDR_W +: ADDR_W];
            data = mem_q[ra];
            hit  = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (bus.we[j] && (bus.waddr[j*ADDR_W +: ADDR_W] == ra)) begin
                    hit  = 1'b1;
                    data = bus.wdata[j*DATA_W +: DATA_W];
                end
            end
            if (is_zero(ra)) begin
                data = '0;
            end
            rdata_c[i*DATA_W +: DATA_W] = data;
            rvalid_c[i] = hit | ~pend_q[ra] | is_zero(ra);
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.rvalid   = rvalid_c;
    assign bus.pend_cnt = pend_cnt_q;

    // Storage, scoreboard and count registers; reset clears everything at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= mem_d[r];
            end
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

`ifdef REGFILE_HILO_EN
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        hilo_pend_q, hilo_pend_d;

    // HI/LO next state; issue outranks a same-cycle write, flush outranks both
    always_comb begin
        hi_d        = bus.hilo_we[1] ? bus.hilo_wdata[63:32] : hi_q;
        lo_d        = bus.hilo_we[0] ? bus.hilo_wdata[31:0]  : lo_q;
        hilo_pend_d = hilo_pend_q;
        if (bus.flush) begin
            hilo_pend_d = 1'b0;
        end else if (bus.hilo_issue) begin
            hilo_pend_d = 1'b1;
        end else if (|bus.hilo_we) begin
            hilo_pend_d = 1'b0;
        end
    end

    // HI/LO read outputs bypass same-cycle writes
    always_comb begin
        bus.hi_rdata  = bus.hilo_we[1] ? bus.hilo_wdata[63:32] : hi_q;
        bus.lo_rdata  = bus.hilo_we[0] ? bus.hilo_wdata[31:0]  : lo_q;
        bus.hilo_pend = hilo_pend_q;
    end

    // HI/LO registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q        <= '0;
            lo_q        <= '0;
            hilo_pend_q <= 1'b0;
        end else begin
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            hilo_pend_q <= hilo_pend_d;
        end
    end
`endif
endmodule
